// File: rtl/slew_pkg.sv
// Shared definitions for the slew-rate checker: FSM state encoding,
// default widths, and the saturating-counter helper.
// Latency: n/a (package). Backpressure: n/a.
package slew_pkg;

  localparam int DEF_DATA_W = 6;
  localparam int DEF_STEP_W = 3;
  localparam int DEF_CNT_W  = 8;

  // Plain 2-bit constants so older tooling and waveform viewers see stable codes.
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE    = 2'd0;  // no reference sample held
  localparam state_t ST_TRACK   = 2'd1;  // reference held, not yet settled
  localparam state_t ST_SETTLED = 2'd2;  // target reached and held

  // Increment v, holding at 2^w-1. Callers cast the result back to their width.
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
    logic [31:0] max_v;
    max_v = (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
    return (v >= max_v) ? v : (v + 32'd1);
  endfunction

endpackage

// File: rtl/slew_abs_delta.sv
// Combinational |a-b| without wrap, plus slew legality against step_size
// with the direct-load exemption (a == target and target <= step_size).
// Latency: 0 cycles (pure combinational). Backpressure: none.
//
// Ports:
//   a, b        : current sample and previous reference
//   target      : unlimited value the limiter is tracking
//   step_size   : maximum permitted change per sample
//   delta       : |a-b| at DATA_W+1 bits
//   legal       : change is within the slew limit or exempt
module slew_abs_delta
  import slew_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int STEP_W = DEF_STEP_W
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [DATA_W-1:0] target,
  input  logic [STEP_W-1:0] step_size,
  output logic [DATA_W:0]   delta,
  output logic              legal
);

  // Common compare width so neither operand is truncated.
  localparam int CW = (DATA_W + 1 > STEP_W) ? DATA_W + 1 : STEP_W;

  logic [DATA_W:0] a_x;
  logic [DATA_W:0] b_x;
  logic [CW-1:0]   d_cmp;
  logic [CW-1:0]   s_cmp;
  logic [CW-1:0]   t_cmp;
  logic            within_step;
  logic            exempt;

  assign a_x   = {1'b0, a};
  assign b_x   = {1'b0, b};
  assign delta = (a_x >= b_x) ? (a_x - b_x) : (b_x - a_x);

  assign d_cmp = CW'(delta);
  assign s_cmp = CW'(step_size);
  assign t_cmp = CW'(target);

  assign within_step = (d_cmp <= s_cmp);
  // The limiter loads small targets directly instead of ramping to them.
  assign exempt      = (a == target) && (t_cmp <= s_cmp);
  assign legal       = within_step || exempt;

endmodule

// File: rtl/slew_monitor.sv
// Slew-rate checker on a rate-limited stream: counts violations, captures the
// first offending delta, and measures time-to-settle on target.
// Latency: all outputs registered, 1 cycle after the valid sample. Backpressure: none (always accepts).
//
// Ports:
//   clk, reset, clear : clock, sync active-high reset, sync soft clear (same effect)
//   valid, sample     : sample strobe and rate-limited data
//   target, step_size : value being tracked and permitted per-sample change
//   violation, viol_count, first_delta : sticky flag, saturating count, first |delta|
//   settled, settle_time, busy         : SETTLED state, latched settle time, TRACK state
module slew_monitor
  import slew_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int STEP_W      = DEF_STEP_W,
  parameter int CNT_W       = DEF_CNT_W,
  parameter int SETTLE_HOLD = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              valid,
  input  logic [DATA_W-1:0] sample,
  input  logic [DATA_W-1:0] target,
  input  logic [STEP_W-1:0] step_size,
  output logic              violation,
  output logic [CNT_W-1:0]  viol_count,
  output logic [DATA_W-1:0] first_delta,
  output logic              settled,
  output logic [CNT_W-1:0]  settle_time,
  output logic              busy
);

  state_t            state_q, state_d;
  logic [DATA_W-1:0] prev_q, prev_d;
  logic [DATA_W-1:0] tgt_q;
  logic              violation_q, violation_d;
  logic [CNT_W-1:0]  viol_cnt_q, viol_cnt_d;
  logic [DATA_W-1:0] first_delta_q, first_delta_d;
  logic [CNT_W-1:0]  timer_q, timer_d;
  logic [CNT_W-1:0]  settle_time_q, settle_time_d;
  logic [3:0]        match_q, match_d;

  logic [DATA_W:0]   delta;
  logic              legal;
  logic              on_tgt;
  logic              tgt_chg;
  logic [3:0]        match_base;

  slew_abs_delta #(
    .DATA_W (DATA_W),
    .STEP_W (STEP_W)
  ) u_delta (
    .a         (sample),
    .b         (prev_q),
    .target    (target),
    .step_size (step_size),
    .delta     (delta),
    .legal     (legal)
  );

  assign on_tgt  = (sample == target);
  assign tgt_chg = (target != tgt_q);

  always_comb begin
    state_d       = state_q;
    prev_d        = prev_q;
    violation_d   = violation_q;
    viol_cnt_d    = viol_cnt_q;
    first_delta_d = first_delta_q;
    timer_d       = timer_q;
    settle_time_d = settle_time_q;
    match_d       = match_q;
    match_base    = 4'd0;

    // Slew check applies to every sample once a reference is held,
    // including the sample that knocks SETTLED back to TRACK.
    if (valid && (state_q != ST_IDLE)) begin
      prev_d = sample;
      if (!legal) begin
        violation_d = 1'b1;
        viol_cnt_d  = CNT_W'(sat_inc(32'(viol_cnt_q), CNT_W));
        if (!violation_q) begin
          first_delta_d = DATA_W'(delta);
        end
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (valid) begin
          prev_d  = sample;
          timer_d = CNT_W'(1);
          match_d = on_tgt ? 4'd1 : 4'd0;
          // SETTLE_HOLD of 1 lets the very first on-target sample settle.
          if (match_d == 4'(SETTLE_HOLD)) begin
            settle_time_d = timer_d;
            state_d       = ST_SETTLED;
          end else begin
            state_d = ST_TRACK;
          end
        end
      end

      ST_TRACK: begin
        if (valid) begin
          timer_d    = CNT_W'(sat_inc(32'(timer_q), CNT_W));
          // A target move restarts the on-target run, but the sample itself may still count.
          match_base = tgt_chg ? 4'd0 : match_q;
          match_d    = on_tgt ? (match_base + 4'd1) : 4'd0;
          if (match_d == 4'(SETTLE_HOLD)) begin
            settle_time_d = timer_d;
            state_d       = ST_SETTLED;
          end
        end else if (tgt_chg) begin
          match_d = 4'd0;
        end
      end

      ST_SETTLED: begin
        if (tgt_chg || (valid && !on_tgt)) begin
          state_d = ST_TRACK;
          timer_d = '0;
          match_d = 4'd0;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      state_q       <= ST_IDLE;
      prev_q        <= '0;
      tgt_q         <= '0;
      violation_q   <= 1'b0;
      viol_cnt_q    <= '0;
      first_delta_q <= '0;
      timer_q       <= '0;
      settle_time_q <= '0;
      match_q       <= 4'd0;
    end else begin
      state_q       <= state_d;
      prev_q        <= prev_d;
      tgt_q         <= target;
      violation_q   <= violation_d;
      viol_cnt_q    <= viol_cnt_d;
      first_delta_q <= first_delta_d;
      timer_q       <= timer_d;
      settle_time_q <= settle_time_d;
      match_q       <= match_d;
    end
  end

  assign violation   = violation_q;
  assign viol_count  = viol_cnt_q;
  assign first_delta = first_delta_q;
  assign settle_time = settle_time_q;
  assign settled     = (state_q == ST_SETTLED);
  assign busy        = (state_q == ST_TRACK);

endmodule

// File: tb/tb_slew_monitor.sv
// Directed self-checking bench for slew_monitor with default parameters.
// Latency: inputs applied just after a rising edge, outputs checked just after the next.
// Backpressure: n/a.
module tb_slew_monitor;

  logic       clk = 1'b0;
  logic       reset;
  logic       clear;
  logic       valid;
  logic [5:0] sample;
  logic [5:0] target;
  logic [2:0] step_size;
  logic       violation;
  logic [7:0] viol_count;
  logic [5:0] first_delta;
  logic       settled;
  logic [7:0] settle_time;
  logic       busy;

  int total = 0;
  int bad   = 0;

  slew_monitor dut (
    .clk         (clk),
    .reset       (reset),
    .clear       (clear),
    .valid       (valid),
    .sample      (sample),
    .target      (target),
    .step_size   (step_size),
    .violation   (violation),
    .viol_count  (viol_count),
    .first_delta (first_delta),
    .settled     (settled),
    .settle_time (settle_time),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic smp(input logic [5:0] s);
    valid  = 1'b1;
    sample = s;
    tick();
    valid  = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".violation"},   32'(violation),   32'd0);
    chk({tag, ".viol_count"},  32'(viol_count),  32'd0);
    chk({tag, ".first_delta"}, 32'(first_delta), 32'd0);
    chk({tag, ".settled"},     32'(settled),     32'd0);
    chk({tag, ".settle_time"}, 32'(settle_time), 32'd0);
    chk({tag, ".busy"},        32'(busy),        32'd0);
  endtask

  initial begin
    reset = 1'b1; clear = 1'b0; valid = 1'b0;
    sample = '0; target = 6'd20; step_size = 3'd3;
    tick(); tick();
    chk_zero("reset");
    reset = 1'b0;

    // Clean ramp 0..18 by 3, then four samples of 20: 11 samples to settle.
    for (int v = 0; v <= 18; v += 3) smp(6'(v));
    smp(6'd20); smp(6'd20); smp(6'd20);
    chk("ramp.not_yet_settled", 32'(settled), 32'd0);
    chk("ramp.busy",            32'(busy),    32'd1);
    smp(6'd20);
    chk("ramp.settled",     32'(settled),     32'd1);
    chk("ramp.settle_time", 32'(settle_time), 32'd11);
    chk("ramp.violation",   32'(violation),   32'd0);
    chk("ramp.busy_low",    32'(busy),        32'd0);

    // Target step while settled: drop to TRACK with no sample, timer restarts.
    target = 6'd40;
    tick();
    chk("retarget.settled", 32'(settled),     32'd0);
    chk("retarget.busy",    32'(busy),        32'd1);
    chk("retarget.st_held", 32'(settle_time), 32'd11);
    for (int v = 23; v <= 38; v += 3) smp(6'(v));
    smp(6'd40); smp(6'd40); smp(6'd40); smp(6'd40);
    chk("retarget.settled2",    32'(settled),     32'd1);
    chk("retarget.settle_time", 32'(settle_time), 32'd10);
    chk("retarget.violation",   32'(violation),   32'd0);

    // First violation captured, later one only counted.
    clear = 1'b1; tick(); clear = 1'b0;
    step_size = 3'd2; target = 6'd63;
    smp(6'd10); smp(6'd15);
    chk("viol1.violation",   32'(violation),   32'd1);
    chk("viol1.count",       32'(viol_count),  32'd1);
    chk("viol1.first_delta", 32'(first_delta), 32'd5);
    smp(6'd25);
    chk("viol2.count",       32'(viol_count),  32'd2);
    chk("viol2.first_delta", 32'(first_delta), 32'd5);

    // Direct-load exemption for a small target.
    clear = 1'b1; tick(); clear = 1'b0;
    step_size = 3'd3; target = 6'd2;
    smp(6'd60); smp(6'd2);
    chk("exempt.violation", 32'(violation), 32'd0);
    clear = 1'b1; tick(); clear = 1'b0;
    target = 6'd5;
    smp(6'd60); smp(6'd2);
    chk("noexempt.violation",   32'(violation),   32'd1);
    chk("noexempt.first_delta", 32'(first_delta), 32'd58);

    // 300 violations saturate the counter at 255.
    clear = 1'b1; tick(); clear = 1'b0;
    smp(6'd0);
    for (int i = 0; i < 300; i++) smp((i % 2 == 0) ? 6'd63 : 6'd0);
    chk("sat.count",       32'(viol_count),  32'd255);
    chk("sat.first_delta", 32'(first_delta), 32'd63);

    // Clear wins over a coincident valid sample, which is discarded.
    clear = 1'b1; valid = 1'b1; sample = 6'd10;
    tick();
    clear = 1'b0; valid = 1'b0;
    chk_zero("clear");
    smp(6'd50);
    chk("after_clear.violation", 32'(violation), 32'd0);
    chk("after_clear.busy",      32'(busy),      32'd1);

    // Reset mid-ramp drops history, including a recorded violation.
    clear = 1'b1; tick(); clear = 1'b0;
    target = 6'd60;
    smp(6'd0); smp(6'd3); smp(6'd10);
    chk("midramp.violation", 32'(violation), 32'd1);
    reset = 1'b1; tick(); reset = 1'b0;
    chk_zero("midreset");
    smp(6'd50);
    chk("after_reset.violation", 32'(violation),  32'd0);
    chk("after_reset.count",     32'(viol_count), 32'd0);
    chk("after_reset.busy",      32'(busy),       32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
